// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode 7-segment scanner with frame-synchronous data
// update, per-digit decimal points, leading-zero suppression, blinking and an anode guard.
module seg_scan_driver #(
  parameter int DIGITS       = 4,
  parameter int DIV          = 1024,
  parameter int GUARD        = 16,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  lz_en,
  input  logic [DIGITS-1:0]     blink_mask,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  seg_dp
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [PW-1:0]         r_presc;
  logic [IW-1:0]         r_idx;
  logic [FW-1:0]         r_frame;
  logic                  r_phase;
  logic                  r_pending;
  logic [4*DIGITS-1:0]   r_shadow_data;
  logic [DIGITS-1:0]     r_shadow_dp;
  logic [4*DIGITS-1:0]   r_disp_data;
  logic [DIGITS-1:0]     r_disp_dp;
  logic [DIGITS-1:0]     r_an;
  logic [6:0]            r_seg;
  logic                  r_seg_dp;

  logic                  w_slot_end;
  logic                  w_frame_end;
  logic                  w_guard;
  logic                  w_hard_blank;
  logic                  w_lz_blank;
  logic                  w_dp_on;
  logic [3:0]            w_nibble;
  logic [6:0]            w_seg_dec;
  logic [3:0]            w_nib [DIGITS];
  logic [DIGITS-1:0]     w_upper_zero;
  logic [DIGITS-1:0]     w_an_next;
  logic [6:0]            w_seg_next;
  logic                  w_seg_dp_next;

  assign w_slot_end  = (r_presc == PW'(DIV - 1));
  assign w_frame_end = w_slot_end && (r_idx == IW'(DIGITS - 1));

  // w_upper_zero[i]: every nibble from the top digit down to digit i is zero.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
    assign w_nib[gi]        = r_disp_data[4*gi +: 4];
    assign w_upper_zero[gi] = (r_disp_data[4*DIGITS-1 : 4*gi] == '0);
  end

  if (GUARD > 0) begin : g_guard
    assign w_guard = (r_presc < PW'(GUARD));
  end else begin : g_no_guard
    assign w_guard = 1'b0;
  end

  assign w_nibble     = w_nib[r_idx];
  assign w_dp_on      = r_disp_dp[r_idx];
  assign w_hard_blank = !ena || w_guard || (blink_mask[r_idx] && r_phase);
  assign w_lz_blank   = lz_en && (r_idx != '0) && w_upper_zero[r_idx];

  always_comb begin
    w_seg_dec = 7'h7F;
    case (w_nibble)
      4'h0: w_seg_dec = 7'h40;
      4'h1: w_seg_dec = 7'h79;
      4'h2: w_seg_dec = 7'h24;
      4'h3: w_seg_dec = 7'h30;
      4'h4: w_seg_dec = 7'h19;
      4'h5: w_seg_dec = 7'h12;
      4'h6: w_seg_dec = 7'h02;
      4'h7: w_seg_dec = 7'h78;
      4'h8: w_seg_dec = 7'h00;
      4'h9: w_seg_dec = 7'h10;
      4'hA: w_seg_dec = 7'h08;
      4'hB: w_seg_dec = 7'h03;
      4'hC: w_seg_dec = 7'h46;
      4'hD: w_seg_dec = 7'h21;
      4'hE: w_seg_dec = 7'h06;
      4'hF: w_seg_dec = 7'h0E;
      default: w_seg_dec = 7'h7F;
    endcase
  end

  // A zero-suppressed digit still lights its anode when it carries a decimal point.
  always_comb begin
    w_an_next     = '1;
    w_seg_next    = 7'h7F;
    w_seg_dp_next = 1'b1;
    if (!w_hard_blank) begin
      if (!w_lz_blank || w_dp_on) begin
        w_an_next = ~(DIGITS'(1) << r_idx);
      end
      if (!w_lz_blank) begin
        w_seg_next = w_seg_dec;
      end
      w_seg_dp_next = ~w_dp_on;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_idx   <= '0;
      r_frame <= '0;
      r_phase <= 1'b0;
    end else begin
      if (w_slot_end) begin
        r_presc <= '0;
        r_idx   <= (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + IW'(1);
      end else begin
        r_presc <= r_presc + PW'(1);
      end
      if (w_frame_end) begin
        if (r_frame == FW'(BLINK_FRAMES - 1)) begin
          r_frame <= '0;
          r_phase <= ~r_phase;
        end else begin
          r_frame <= r_frame + FW'(1);
        end
      end
    end
  end

  // Display only changes on a frame boundary so a frame never mixes old and new digits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending     <= 1'b0;
      r_shadow_data <= '0;
      r_shadow_dp   <= '0;
      r_disp_data   <= '0;
      r_disp_dp     <= '0;
    end else begin
      if (load) begin
        r_shadow_data <= data;
        r_shadow_dp   <= dp;
      end
      if (w_frame_end) begin
        r_pending <= 1'b0;
        if (load) begin
          r_disp_data <= data;
          r_disp_dp   <= dp;
        end else if (r_pending) begin
          r_disp_data <= r_shadow_data;
          r_disp_dp   <= r_shadow_dp;
        end
      end else if (load) begin
        r_pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an     <= '1;
      r_seg    <= 7'h7F;
      r_seg_dp <= 1'b1;
    end else begin
      r_an     <= w_an_next;
      r_seg    <= w_seg_next;
      r_seg_dp <= w_seg_dp_next;
    end
  end

  assign an     = r_an;
  assign seg    = r_seg;
  assign seg_dp = r_seg_dp;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: cycle-accurate model derived from elapsed-cycle arithmetic,
// checked every cycle, plus a table of hand-computed expectations at chosen cycles.
module tb_seg_scan_driver;
  localparam int DIGITS = 4;
  localparam int DIV    = 4;
  localparam int GUARD  = 1;
  localparam int BF     = 2;
  localparam int FL     = DIV * DIGITS;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b0;
  logic        load = 1'b0;
  logic [15:0] data = '0;
  logic [3:0]  dp = '0;
  logic        lz_en = 1'b0;
  logic [3:0]  blink_mask = '0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        seg_dp;

  always #5 clk = ~clk;

  seg_scan_driver #(.DIGITS(DIGITS), .DIV(DIV), .GUARD(GUARD), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .load(load), .data(data), .dp(dp),
    .lz_en(lz_en), .blink_mask(blink_mask), .an(an), .seg(seg), .seg_dp(seg_dp)
  );

  typedef struct { int c; logic [15:0] d; logic [3:0] p; } ld_t;
  typedef struct { int ep; int t; logic [3:0] an; logic [6:0] seg; logic dp; string name; } lit_t;

  ld_t         ldq[$];
  lit_t        lit[$];
  logic [6:0]  dec_tab [16];
  int          cyc;
  int          epoch = 0;
  int          li = 0;
  bit          done = 1'b0;
  logic [11:0] exp_vec;
  int          checks = 0;
  int          errors = 0;

  // Outputs during cycle t+1 follow from the scan position of cycle t, the live
  // inputs of cycle t and the last load strictly before the current frame started.
  function automatic logic [11:0] model_expect(input int t, input logic en, input logic lz,
                                               input logic [3:0] bm);
    int presc, idx, fstart, phase;
    logic [15:0] d, upper;
    logic [3:0]  p, a;
    logic [6:0]  s;
    logic        sd, hard, lzb, dpon;
    presc  = t % DIV;
    idx    = (t / DIV) % DIGITS;
    fstart = (t / FL) * FL;
    phase  = ((t / FL) / BF) % 2;
    d = '0;
    p = '0;
    foreach (ldq[k]) begin
      if (ldq[k].c < fstart) begin
        d = ldq[k].d;
        p = ldq[k].p;
      end
    end
    upper = d >> (4 * idx);
    hard  = !en || (presc < GUARD) || (bm[idx] && phase == 1);
    lzb   = lz && (idx != 0) && (upper == 16'h0);
    dpon  = p[idx];
    a  = 4'hF;
    s  = 7'h7F;
    sd = 1'b1;
    if (!hard) begin
      if (!lzb || dpon) a = ~(4'(1) << idx);
      if (!lzb) s = dec_tab[upper[3:0]];
      sd = ~dpon;
    end
    return {a, s, sd};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc <= 0;
      ldq.delete();
      exp_vec <= 12'hFFF;
    end else begin
      exp_vec <= model_expect(cyc, ena, lz_en, blink_mask);
      if (load) ldq.push_back('{cyc, data, dp});
      cyc <= cyc + 1;
    end
  end

  always @(negedge clk or negedge rst_n) begin
    #1;
    checks++;
    if ({an, seg, seg_dp} !== exp_vec) begin
      errors++;
      $display("FAIL model ep=%0d t=%0d got an=%b seg=%h dp=%b want an=%b seg=%h dp=%b",
               epoch, cyc - 1, an, seg, seg_dp, exp_vec[11:8], exp_vec[7:1], exp_vec[0]);
    end
    checks++;
    if (!$onehot0(~an)) begin
      errors++;
      $display("FAIL onehot t=%0d got an=%b want at most one low bit", cyc - 1, an);
    end
    if (rst_n && li < lit.size() && lit[li].ep == epoch && cyc == lit[li].t + 1) begin
      checks++;
      if ({an, seg, seg_dp} !== {lit[li].an, lit[li].seg, lit[li].dp}) begin
        errors++;
        $display("FAIL %s t=%0d got an=%b seg=%h dp=%b want an=%b seg=%h dp=%b", lit[li].name,
                 lit[li].t, an, seg, seg_dp, lit[li].an, lit[li].seg, lit[li].dp);
      end else begin
        $display("check %s t=%0d an=%b seg=%h dp=%b ok", lit[li].name, lit[li].t, an, seg, seg_dp);
      end
      li++;
    end
    if (done) begin
      checks++;
      if (li != lit.size()) begin
        errors++;
        $display("FAIL literal_coverage got %0d reached want %0d", li, lit.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  function automatic void add(input int ep, input int t, input logic [3:0] a,
                              input logic [6:0] s, input logic d, input string n);
    lit.push_back('{ep, t, a, s, d, n});
  endfunction

  task automatic goto(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic do_load(input int t, input logic [15:0] d, input logic [3:0] p);
    goto(t);
    load = 1'b1;
    data = d;
    dp   = p;
    goto(t + 1);
    load = 1'b0;
  endtask

  initial begin
    dec_tab[0]  = 7'h40; dec_tab[1]  = 7'h79; dec_tab[2]  = 7'h24; dec_tab[3]  = 7'h30;
    dec_tab[4]  = 7'h19; dec_tab[5]  = 7'h12; dec_tab[6]  = 7'h02; dec_tab[7]  = 7'h78;
    dec_tab[8]  = 7'h00; dec_tab[9]  = 7'h10; dec_tab[10] = 7'h08; dec_tab[11] = 7'h03;
    dec_tab[12] = 7'h46; dec_tab[13] = 7'h21; dec_tab[14] = 7'h06; dec_tab[15] = 7'h0E;

    add(0,   6, 4'b1101, 7'h40, 1'b1, "frame0_shows_zero");
    add(0,  16, 4'b1111, 7'h7F, 1'b1, "guard_clock");
    add(0,  17, 4'b1110, 7'h0E, 1'b1, "d0_F");
    add(0,  21, 4'b1101, 7'h08, 1'b1, "d1_A");
    add(0,  25, 4'b1011, 7'h24, 1'b1, "d2_2");
    add(0,  29, 4'b0111, 7'h79, 1'b1, "d3_1");
    add(0,  49, 4'b1110, 7'h78, 1'b1, "lz_d0_7");
    add(0,  53, 4'b1111, 7'h7F, 1'b1, "lz_d1_dark");
    add(0,  61, 4'b1111, 7'h7F, 1'b1, "lz_d3_dark");
    add(0,  69, 4'b1101, 7'h40, 1'b1, "nolz_d1_0");
    add(0,  81, 4'b1110, 7'h40, 1'b1, "lz_all0_d0");
    add(0,  93, 4'b1111, 7'h7F, 1'b1, "lz_all0_d3");
    add(0,  97, 4'b1110, 7'h79, 1'b1, "blink_d0_lit");
    add(0, 101, 4'b1111, 7'h7F, 1'b1, "blink_d1_dark");
    add(0, 133, 4'b1101, 7'h24, 1'b1, "blink_d1_lit");
    add(0, 165, 4'b1111, 7'h7F, 1'b1, "blink_d1_dark2");
    add(0, 193, 4'b1110, 7'h30, 1'b1, "boundary_load_d0");
    add(0, 197, 4'b1101, 7'h30, 1'b1, "boundary_load_d1");
    add(0, 209, 4'b1110, 7'h12, 1'b1, "dp_d0_5");
    add(0, 213, 4'b1111, 7'h7F, 1'b1, "dp_d1_dark");
    add(0, 217, 4'b1011, 7'h7F, 1'b0, "dp_d2_point");
    add(0, 221, 4'b1111, 7'h7F, 1'b1, "dp_d3_dark");
    add(0, 242, 4'b1110, 7'h12, 1'b1, "pre_reset_lit");
    add(1,   0, 4'b1111, 7'h7F, 1'b1, "post_reset_guard");
    add(1,   1, 4'b1110, 7'h40, 1'b1, "post_reset_d0");
    add(1,   5, 4'b1111, 7'h7F, 1'b1, "ena0_d1");
    add(1,   9, 4'b1111, 7'h7F, 1'b1, "ena0_d2");
    add(1,  22, 4'b1101, 7'h40, 1'b1, "ena1_d1");

    ena = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    do_load(2, 16'h12AF, 4'b0000);
    do_load(34, 16'h0007, 4'b0000);
    goto(48);  lz_en = 1'b1;
    goto(64);  lz_en = 1'b0;
    do_load(66, 16'h0000, 4'b0000);
    goto(80);  lz_en = 1'b1;
    do_load(82, 16'h4321, 4'b0000);
    goto(96);  lz_en = 1'b0; blink_mask = 4'b0010;
    goto(176); blink_mask = 4'b0000;
    do_load(178, 16'h1111, 4'b0000);
    do_load(185, 16'h2222, 4'b0000);
    do_load(191, 16'h3333, 4'b0000);
    goto(200); lz_en = 1'b1;
    do_load(200, 16'h0005, 4'b0100);

    goto(243);
    #2;
    epoch = 1;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    lz_en = 1'b0;
    rst_n = 1'b1;
    goto(5);  ena = 1'b0;
    goto(20); ena = 1'b1;
    goto(40);
    done = 1'b1;
    forever @(negedge clk);
  end
endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
Time-multiplexed driver for a bank of DIGITS common-anode 7-segment displays sharing one active-low segment bus. It latches a packed hex value, scans the digits one at a time, and supports per-digit decimal points, leading-zero suppression, per-digit blinking and an anti-ghosting guard interval. It sits between core status registers and the board display pins and replaces per-digit static decoders.

Parameters:
DIGITS, 4, number of digits scanned (1..8)
DIV, 1024, clocks per digit slot (>= GUARD+1)
GUARD, 16, clocks at the start of each slot with all anodes off (0 = no guard)
BLINK_FRAMES, 64, full scan frames per blink half-period (>= 1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ena  in  1  display enable; 0 blanks all outputs, counters keep running
load  in  1  one-cycle strobe: capture data/dp into shadow register
data  in  4*DIGITS  packed nibbles, digit 0 = data[3:0] (rightmost, least significant)
dp  in  DIGITS  decimal point request per digit, captured with load
lz_en  in  1  leading-zero suppression enable (live, not latched)
blink_mask  in  DIGITS  digits to blink (live, not latched)
an  out  DIGITS  anode selects, active-low, registered
seg  out  7  segments {g,f,e,d,c,b,a}, active-low, registered
seg_dp  out  1  decimal point, active-low, registered

Behaviour:
- Reset (async assert, sync release): an = all 1, seg = 7'h7F, seg_dp = 1; prescaler, digit index, frame counter, blink phase, pending flag, shadow and display registers = 0.
- Prescaler counts 0..DIV-1 and wraps. On wrap, the digit index advances; DIGITS-1 wraps to 0, which is a frame boundary.
- Frame counter counts frame boundaries 0..BLINK_FRAMES-1. On wrap, blink phase toggles.
- load: data/dp go into the shadow register and pending is set. At the next frame boundary, shadow copies to display and pending clears. No tearing mid-frame.
- load on the frame-boundary cycle itself: new data/dp go straight to display, pending stays 0. Back-to-back loads: the last one before the boundary wins.
- Digit i blank condition: ena=0, OR prescaler < GUARD, OR (blink_mask[i] and phase=1), OR (lz_en and i != 0 and nibbles DIGITS-1..i of display are all zero).
- Decimal points are never suppressed by leading-zero suppression. They are suppressed by ena, guard and blink.
- Outputs are registered: one clock after the prescaler/index values that produce them.
  - Active slot, not blank: an = one-hot-low at index; seg = decode of display nibble; seg_dp = ~dp[index].
  - Blank: an = all 1, seg = 7'h7F, seg_dp = 1.
- Decode, active-low {g..a}:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex)
- Never more than one an bit low in any cycle.
- Reset mid-frame: outputs blank immediately (async); scan restarts at digit 0, prescaler 0.
- ena toggling does not disturb scan timing or the display contents.

Test Plan:
Use DIGITS=4, DIV=4, GUARD=1, BLINK_FRAMES=2 throughout.
1. Reset then load data=16'h12AF, dp=0 -> 0 displayed until the first frame boundary. Next frame: digit0 slot an=4'b1110, seg=7'h0E; digit1 7'h08; digit2 7'h24; digit3 7'h79. Each digit is valid 3 clocks, blank 1 guard clock.
2. Load 16'h0007, lz_en=1 -> digits 3..1 keep an=4'b1111 in their slots; digit0 shows 7'h78. With lz_en=0, digits 3..1 show 7'h40. Load 16'h0000 with lz_en=1 -> only digit0 lit, showing 7'h40.
3. blink_mask=4'b0010 -> digit1 lit for 2 frames, dark for 2 frames, alternating. Other digits unaffected.
4. Load 16'h1111, then load 16'h2222 mid-frame, then load 16'h3333 exactly on the frame-boundary cycle -> 16'h3333 is shown from that frame. 16'h1111 and 16'h2222 are never shown.
5. dp=4'b0100 with lz_en=1 and data 16'h0005 -> digit2 slot: an=4'b1011, seg=7'h7F, seg_dp=0.
6. Assert rst_n=0 mid-slot -> an, seg and seg_dp go all-1 in the same cycle, with no clock edge needed. After release, digit0 is the first lit slot, lit after GUARD+1 clocks. With ena=0, the bench confirms an stays all-1 while the index keeps advancing.
